// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/forwarding unit.
//   - FWD_* : 2-bit EX operand mux select codes
//   - state_e : load-use FSM state encoding (ST_RUN, ST_LDSTALL)
//   - trk_t : per-stage tracking entry {dest, we, ld}
//   - dbg_t : debug snapshot of FSM state and all three tracking entries
package hazard_pkg;

  localparam int REG_W_P = 5;
  localparam int SEL_W_P = 2;

  localparam logic [SEL_W_P-1:0] FWD_RF    = 2'b00;
  localparam logic [SEL_W_P-1:0] FWD_EXMEM = 2'b01;
  localparam logic [SEL_W_P-1:0] FWD_MEMWB = 2'b10;
  localparam logic [SEL_W_P-1:0] FWD_WB    = 2'b11;

  localparam logic [REG_W_P-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_LDSTALL = 1'b1
  } state_e;

  typedef struct packed {
    logic [REG_W_P-1:0] dest;
    logic               we;
    logic               ld;
  } trk_t;

  localparam trk_t TRK_BUBBLE = '{dest: REG_ZERO, we: 1'b0, ld: 1'b0};

  typedef struct packed {
    state_e state;
    trk_t   ex;
    trk_t   mem;
    trk_t   wb;
  } dbg_t;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: combinational forwarding select for one EX operand.
// Ports:
//   i_src      - source register index of the ID instruction
//   i_use      - the instruction actually reads i_src
//   i_*_dest / i_*_we - destination and write-enable of the EX, MEM, WB entries
//   o_sel      - select code; youngest matching producer wins (EX > MEM > WB)
module fwd_match
  import hazard_pkg::*;
(
  input  logic [REG_W_P-1:0] i_src,
  input  logic               i_use,
  input  logic [REG_W_P-1:0] i_ex_dest,
  input  logic               i_ex_we,
  input  logic [REG_W_P-1:0] i_mem_dest,
  input  logic               i_mem_we,
  input  logic [REG_W_P-1:0] i_wb_dest,
  input  logic               i_wb_we,
  output logic [SEL_W_P-1:0] o_sel
);

  // Entries with dest == $0 were stored with we = 0, so no explicit
  // zero check is needed here.
  always_comb begin
    o_sel = FWD_RF;
    if (i_use) begin
      if (i_ex_we && (i_ex_dest == i_src)) begin
        o_sel = FWD_EXMEM;
      end else if (i_mem_we && (i_mem_dest == i_src)) begin
        o_sel = FWD_MEMWB;
      end else if (i_wb_we && (i_wb_dest == i_src)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard detection and operand forwarding control for a
// 5-stage pipeline. Tracks {dest, we, ld} through EX/MEM/WB, registers the
// EX operand mux selects and raises a one-cycle load-use stall.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   id_*                - ID-stage decode fields
//   flush               - squash the ID instruction (EX gets a bubble)
//   ext_stall           - global freeze; no state changes, stall forced 0
//   fwd_a_sel/fwd_b_sel - registered EX operand selects
//   stall               - combinational load-use stall
//   stall_count         - load-use stall count (built only when the
//                         HAZ_STATS_EN macro is defined, else tied to 0)
//   dbg_state           - FSM state and tracking entries for observation
// Handshake: none; every ID field is sampled on each rising edge unless
// ext_stall is high, and an asserted stall means the same ID fields are
// re-presented on the following cycle.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             ext_stall,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic             stall,
  output logic [31:0]      stall_count,
  output dbg_t             dbg_state
);

  state_e           r_state;
  trk_t             r_ex, r_mem, r_wb;
  logic [SEL_W-1:0] r_a_sel, r_b_sel;

  trk_t             w_id_trk;
  logic [SEL_W-1:0] w_a_sel, w_b_sel;
  logic             w_load_use;
  logic             w_take_stall;

  // $0 is never forwarded, so a write to it is recorded as no write.
  assign w_id_trk = '{dest: id_dest,
                      we:   id_valid & id_reg_write & (id_dest != REG_ZERO),
                      ld:   id_valid & id_mem_read};

  assign w_load_use = id_valid & r_ex.we & r_ex.ld &
                      ((id_use_rs & (id_rs == r_ex.dest)) |
                       (id_use_rt & (id_rt == r_ex.dest)));

  // In LDSTALL the EX entry is a bubble, so the condition cannot recur;
  // the state term just makes that explicit.
  assign w_take_stall = (r_state == ST_RUN) & w_load_use & ~flush & ~ext_stall;
  assign stall        = w_take_stall;

  fwd_match u_match_a (
    .i_src      (id_rs),
    .i_use      (id_use_rs),
    .i_ex_dest  (r_ex.dest),
    .i_ex_we    (r_ex.we),
    .i_mem_dest (r_mem.dest),
    .i_mem_we   (r_mem.we),
    .i_wb_dest  (r_wb.dest),
    .i_wb_we    (r_wb.we),
    .o_sel      (w_a_sel)
  );

  fwd_match u_match_b (
    .i_src      (id_rt),
    .i_use      (id_use_rt),
    .i_ex_dest  (r_ex.dest),
    .i_ex_we    (r_ex.we),
    .i_mem_dest (r_mem.dest),
    .i_mem_we   (r_mem.we),
    .i_wb_dest  (r_wb.dest),
    .i_wb_we    (r_wb.we),
    .o_sel      (w_b_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_ex    <= TRK_BUBBLE;
      r_mem   <= TRK_BUBBLE;
      r_wb    <= TRK_BUBBLE;
      r_a_sel <= FWD_RF;
      r_b_sel <= FWD_RF;
    end else if (!ext_stall) begin
      // MEM and WB always advance; only the EX entry depends on the hazard.
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (flush || w_take_stall) begin
        r_ex    <= TRK_BUBBLE;
        r_a_sel <= FWD_RF;
        r_b_sel <= FWD_RF;
      end else begin
        r_ex    <= w_id_trk;
        r_a_sel <= w_a_sel;
        r_b_sel <= w_b_sel;
      end
      if (w_take_stall) begin
        r_state <= ST_LDSTALL;
      end else begin
        r_state <= ST_RUN;
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stall_count;

  // w_take_stall already excludes ext_stall, so the counter freezes with
  // the rest of the state; it wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= 32'd0;
    end else if (w_take_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

  assign fwd_a_sel = r_a_sel;
  assign fwd_b_sel = r_b_sel;

  assign dbg_state = '{state: r_state, ex: r_ex, mem: r_mem, wb: r_wb};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed bench for hazard_fwd_unit. Expected select
// pairs are queued when an ID instruction is driven and popped after the
// following rising edge; stall is checked combinationally before the edge.
module tb_hazard_fwd_unit;
  import hazard_pkg::*;

`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       flush, ext_stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;
  logic [31:0] stall_count;
  dbg_t       dbg;

  hazard_fwd_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .ext_stall    (ext_stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .stall_count  (stall_count),
    .dbg_state    (dbg)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drv(input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt, input logic [4:0] dest,
                     input logic rw, input logic mr, input logic fl, input logic xs);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr; flush = fl; ext_stall = xs;
  endtask

  // Called at a falling edge after drv: check stall, queue the selects the
  // next rising edge must produce, then compare them just after that edge.
  task automatic step(input string tag, input logic es, input logic [1:0] ea,
                      input logic [1:0] eb);
    logic [3:0] e;
    #2;
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, es});
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sels"}, {28'd0, fwd_a_sel, fwd_b_sel}, {28'd0, e});
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_sels", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dbg", 32'(dbg), 32'd0);
    chk("rst_cnt", stall_count, 32'd0);
    rst = 1'b0;

    // Test 1: EX/MEM forwarding
    drv(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);   step("t1_prod", 0, 2'b00, 2'b00);
    drv(1, 3, 1, 4, 1, 6, 1, 0, 0, 0);   step("t1_cons", 0, 2'b01, 2'b00);

    // Test 2: MEM/WB and WB forwarding, priority, unused operands
    drv(1, 7, 1, 8, 1, 5, 1, 0, 0, 0);   step("t2_prod", 0, 2'b00, 2'b00);
    drv(1, 9, 1, 10, 1, 11, 1, 0, 0, 0); step("t2_ind", 0, 2'b00, 2'b00);
    drv(1, 12, 1, 5, 1, 13, 1, 0, 0, 0); step("t2_memwb", 0, 2'b00, 2'b10);
    drv(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);   step("t2_prod2", 0, 2'b00, 2'b00);
    drv(1, 16, 1, 17, 1, 15, 1, 0, 0, 0); step("t2_ind2", 0, 2'b00, 2'b00);
    drv(1, 16, 1, 17, 1, 18, 1, 0, 0, 0); step("t2_ind3", 0, 2'b00, 2'b00);
    drv(1, 18, 1, 5, 1, 18, 1, 0, 0, 0); step("t2_wb", 0, 2'b01, 2'b11);
    drv(1, 18, 1, 15, 1, 20, 1, 0, 0, 0); step("t2_prio", 0, 2'b01, 2'b11);
    drv(1, 18, 0, 18, 0, 0, 0, 0, 0, 0); step("t2_unused", 0, 2'b00, 2'b00);

    // Test 4: writes to $0 are never forwarded
    drv(1, 1, 1, 2, 1, 0, 1, 0, 0, 0);   step("t4_wr0", 0, 2'b00, 2'b00);
    chk("t4_ex_we0", {25'd0, dbg.ex}, 32'd0);
    drv(1, 0, 1, 0, 1, 21, 1, 0, 0, 0);  step("t4_rd0", 0, 2'b00, 2'b00);

    // Test 3: load-use, single stall, then back-to-back pairs
    drv(1, 1, 1, 2, 0, 7, 1, 1, 0, 0);   step("t3_lw7", 0, 2'b00, 2'b00);
    drv(1, 7, 1, 3, 0, 22, 1, 0, 0, 0);  step("t3_use", 1, 2'b00, 2'b00);
    chk("t3_st_ld", {31'd0, dbg.state}, {31'd0, ST_LDSTALL});
    chk("t3_cnt1", stall_count, exp_cnt(1));
    step("t3_rep", 0, 2'b10, 2'b00);
    chk("t3_st_run", {31'd0, dbg.state}, {31'd0, ST_RUN});
    drv(1, 22, 1, 0, 0, 8, 1, 1, 0, 0);  step("t3_lw8", 0, 2'b01, 2'b00);
    drv(1, 0, 0, 8, 1, 9, 1, 1, 0, 0);   step("t3_use8", 1, 2'b00, 2'b00);
    step("t3_rep8", 0, 2'b00, 2'b10);
    drv(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);  step("t3_use9", 1, 2'b00, 2'b00);
    step("t3_rep9", 0, 2'b10, 2'b00);
    chk("t3_cnt3", stall_count, exp_cnt(3));

    // Test 5: flush wins over a simultaneous load-use
    drv(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);  step("t5_lw11", 0, 2'b00, 2'b00);
    drv(1, 11, 1, 0, 0, 12, 1, 0, 1, 0); step("t5_flush", 0, 2'b00, 2'b00);
    chk("t5_st", {31'd0, dbg.state}, {31'd0, ST_RUN});
    chk("t5_ex", {25'd0, dbg.ex}, 32'd0);
    chk("t5_cnt", stall_count, exp_cnt(3));
    drv(1, 11, 1, 0, 0, 12, 1, 1, 0, 0); step("t5_after", 0, 2'b10, 2'b00);

    // Test 6a: ext_stall freezes everything, masks a pending load-use
    drv(1, 12, 1, 0, 0, 13, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("t6_frz", 0, 2'b10, 2'b00);
      chk("t6_dbg", 32'(dbg), 32'({1'b0, 5'd12, 2'b11, 7'd0, 5'd11, 2'b11}));
      chk("t6_cnt", stall_count, exp_cnt(3));
    end
    drv(1, 12, 1, 0, 0, 13, 1, 0, 0, 0); step("t6_rel", 1, 2'b00, 2'b00);
    chk("t6_st_ld", {31'd0, dbg.state}, {31'd0, ST_LDSTALL});
    chk("t6_cnt4", stall_count, exp_cnt(4));

    // Test 6b: asynchronous reset while in LDSTALL
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_sels", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
    chk("t6_rst_stall", {31'd0, stall}, 32'd0);
    chk("t6_rst_dbg", 32'(dbg), 32'd0);
    chk("t6_rst_cnt", stall_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   step("t6_idle", 0, 2'b00, 2'b00);

    chk("q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
